// File: rtl/display_input_loader_if.sv
// Switch/button inputs and display-side outputs of the display input loader.
interface display_input_loader_if;
  localparam int unsigned DATA_W = 16;

  logic [DATA_W-1:0] sw;
  logic              btn_load;
  logic              btn_clear;
  logic [DATA_W-1:0] Datos;
  logic              write;
  logic              res;
  logic              busy;

  modport master (
    output sw, btn_load, btn_clear,
    input  Datos, write, res, busy
  );

  modport slave (
    input  sw, btn_load, btn_clear,
    output Datos, write, res, busy
  );
endinterface

// File: rtl/display_input_loader.sv
// Synchronizes/debounces switches and load/clear buttons, captures the switch word and
// emits stretched write/res levels for the display. Optional macro: AUTO_REPEAT_EN.
module display_input_loader #(
  parameter int unsigned DEB_CYCLES     = 1000000,
  parameter int unsigned STRETCH_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES  = 50000000
) (
  input logic                   clk,
  input logic                   rstn,
  display_input_loader_if.slave bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);
  localparam int unsigned STR_W  = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;

  if (DEB_CYCLES < 2 || STRETCH_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("display_input_loader: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, LOAD, CLEAR, WAIT_REL} state_t;

  // Bit 0 is load, bit 1 is clear throughout.
  logic [DATA_W-1:0]       sw_s1, sw_s2;
  logic [1:0]              btn_s1, btn_s2, btn_deb, btn_deb_q, btn_rise;
  logic [1:0][DEB_W-1:0]   deb_cnt;

  state_t            state, state_nx;
  logic [STR_W-1:0]  str_cnt, str_cnt_nx;
  logic [DATA_W-1:0] datos_q, datos_nx;
  logic              write_q, res_q, busy_q;

  // Input synchronizers and per-button debounce counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      btn_s1    <= '0;
      btn_s2    <= '0;
      btn_deb   <= '0;
      btn_deb_q <= '0;
      deb_cnt   <= '0;
    end else begin
      sw_s1     <= bus.sw;
      sw_s2     <= sw_s1;
      btn_s1    <= {bus.btn_clear, bus.btn_load};
      btn_s2    <= btn_s1;
      btn_deb_q <= btn_deb;
      for (int i = 0; i < 2; i++) begin
        if (btn_s2[i] == btn_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          btn_deb[i] <= ~btn_deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_rise = btn_deb & ~btn_deb_q;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic [REP_W-1:0] rep_cnt, rep_cnt_nx;
  logic             rep_armed, rep_armed_nx;
`endif

  always_comb begin
    state_nx   = state;
    str_cnt_nx = str_cnt;
    datos_nx   = datos_q;
`ifdef AUTO_REPEAT_EN
    rep_cnt_nx   = '0;
    rep_armed_nx = rep_armed;
`endif
    case (state)
      IDLE: begin
        if (btn_rise[1]) begin
          state_nx = CLEAR;
          datos_nx = '0;
        end else if (btn_rise[0]) begin
          state_nx = LOAD;
          datos_nx = sw_s2;
        end
      end
      LOAD, CLEAR: begin
        if (str_cnt == STR_W'(STRETCH_CYCLES - 1)) begin
          state_nx   = WAIT_REL;
          str_cnt_nx = '0;
        end else begin
          str_cnt_nx = str_cnt + 1'b1;
        end
      end
      WAIT_REL: begin
        if (btn_deb == 2'b00) begin
          state_nx = IDLE;
        end
`ifdef AUTO_REPEAT_EN
        // Only a held load re-fires; a wait entered from CLEAR is never armed.
        else if (rep_armed && btn_deb[0]) begin
          if (rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
            state_nx = LOAD;
            datos_nx = sw_s2;
          end else begin
            rep_cnt_nx = rep_cnt + 1'b1;
          end
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
`ifdef AUTO_REPEAT_EN
    if (state_nx == LOAD) begin
      rep_armed_nx = 1'b1;
    end else if (state_nx == CLEAR) begin
      rep_armed_nx = 1'b0;
    end
`endif
  end

  // State and registered outputs, aligned with the state they decode
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      str_cnt <= '0;
      datos_q <= '0;
      write_q <= 1'b0;
      res_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      str_cnt <= str_cnt_nx;
      datos_q <= datos_nx;
      write_q <= (state_nx == LOAD);
      res_q   <= (state_nx == CLEAR);
      busy_q  <= (state_nx != IDLE);
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt_nx;
      rep_armed <= rep_armed_nx;
    end
  end
`endif

  assign bus.Datos = datos_q;
  assign bus.write = write_q;
  assign bus.res   = res_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_display_input_loader.sv
// Scoreboard bench for display_input_loader with DEB=4, STRETCH=3, REPEAT=10.
module tb_display_input_loader;
  localparam int unsigned LAT = 7;
  localparam int unsigned STRETCH = 3;

  typedef struct {
    logic        is_clear;
    logic [15:0] data;
    int unsigned cyc;
  } exp_t;

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;
  int unsigned cyc  = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb[$];

  display_input_loader_if dif ();

  display_input_loader #(
    .DEB_CYCLES    (4),
    .STRETCH_CYCLES(3),
    .REPEAT_CYCLES (10)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (dif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_strobe(input logic is_clear, input logic [15:0] data, input int unsigned at);
    exp_t e;
    e.is_clear = is_clear;
    e.data     = data;
    e.cyc      = at;
    sb.push_back(e);
  endtask

  // Output monitor: pops an expectation on each strobe rise, checks width and stability
  logic        w_prev = 1'b0, r_prev = 1'b0;
  int unsigned w_len = 0, r_len = 0;
  logic [15:0] w_data = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      w_prev = 1'b0;
      r_prev = 1'b0;
      w_len  = 0;
      r_len  = 0;
    end else begin
      if (dif.write && dif.res) check("write_res_exclusive", 32'(2'b11), 32'(2'b01));
      if ((dif.write && !w_prev) || (dif.res && !r_prev)) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe_queue", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("strobe_kind", 32'(dif.res), 32'(e.is_clear));
          check("strobe_datos", 32'(dif.Datos), 32'(e.data));
          check("strobe_cycle", cyc, e.cyc);
          check("strobe_busy", 32'(dif.busy), 32'd1);
        end
      end
      if (dif.write && !w_prev) begin
        w_len  = 1;
        w_data = dif.Datos;
      end else if (dif.write) begin
        w_len++;
        check("datos_stable", 32'(dif.Datos), 32'(w_data));
      end
      if (!dif.write && w_prev) check("write_width", w_len, STRETCH);
      if (dif.res && !r_prev) r_len = 1;
      else if (dif.res) r_len++;
      if (!dif.res && r_prev) check("res_width", r_len, STRETCH);
      w_prev = dif.write;
      r_prev = dif.res;
    end
  end

  initial begin
    int unsigned d;
    dif.sw        = '0;
    dif.btn_load  = 1'b0;
    dif.btn_clear = 1'b0;

    #2 rstn = 1'b0;
    #1;
    check("rst_datos", 32'(dif.Datos), 32'd0);
    check("rst_write", 32'(dif.write), 32'd0);
    check("rst_res",   32'(dif.res),   32'd0);
    check("rst_busy",  32'(dif.busy),  32'd0);
    step(3);
    rstn = 1'b1;
    step(2);

    // Clean load
    dif.sw = 16'hA5C3;
    step(3);
    dif.btn_load = 1'b1;
    d = cyc;
    expect_strobe(1'b0, 16'hA5C3, d + LAT);
    step(9);
    check("load_busy_strobe", 32'(dif.busy), 32'd1);
    step(3);
    dif.btn_load = 1'b0;
    step(4);
    check("load_busy_wait_rel", 32'(dif.busy), 32'd1);
    step(6);
    check("load_idle_after_rel", 32'(dif.busy), 32'd0);
    check("load_datos_held", 32'(dif.Datos), 32'h0000A5C3);

    // Bouncing load button
    dif.sw = 16'h0F0F;
    for (int i = 0; i < 4; i++) begin
      dif.btn_load = ~i[0];
      step(2);
    end
    step(4);
    check("bounce_no_busy", 32'(dif.busy), 32'd0);
    dif.btn_load = 1'b1;
    d = cyc;
    expect_strobe(1'b0, 16'h0F0F, d + LAT);
    step(12);
    dif.btn_load = 1'b0;
    step(12);

    // Load 1234 then clear
    dif.sw = 16'h1234;
    step(3);
    dif.btn_load = 1'b1;
    d = cyc;
    expect_strobe(1'b0, 16'h1234, d + LAT);
    step(12);
    dif.btn_load = 1'b0;
    step(12);
    check("pre_clear_datos", 32'(dif.Datos), 32'h00001234);
    dif.btn_clear = 1'b1;
    d = cyc;
    expect_strobe(1'b1, 16'h0000, d + LAT);
    step(12);
    dif.btn_clear = 1'b0;
    step(12);
    check("post_clear_datos", 32'(dif.Datos), 32'd0);

    // Simultaneous clear and load: clear wins, nothing queued
    dif.sw = 16'hBEEF;
    step(3);
    dif.btn_load  = 1'b1;
    dif.btn_clear = 1'b1;
    d = cyc;
    expect_strobe(1'b1, 16'h0000, d + LAT);
    step(14);
    check("simul_wait_rel_busy", 32'(dif.busy), 32'd1);
    dif.btn_load  = 1'b0;
    dif.btn_clear = 1'b0;
    step(12);
    check("simul_idle", 32'(dif.busy), 32'd0);
    dif.btn_load = 1'b1;
    d = cyc;
    expect_strobe(1'b0, 16'hBEEF, d + LAT);
    step(12);
    dif.btn_load = 1'b0;
    step(12);

    // Reset during the second write cycle, button held through release
    dif.sw = 16'h5A5A;
    dif.btn_load = 1'b1;
    d = cyc;
    expect_strobe(1'b0, 16'h5A5A, d + LAT);
    step(8);
    rstn = 1'b0;
    #1;
    check("midrst_write", 32'(dif.write), 32'd0);
    check("midrst_busy",  32'(dif.busy),  32'd0);
    check("midrst_datos", 32'(dif.Datos), 32'd0);
    check("midrst_res",   32'(dif.res),   32'd0);
    step(2);
    rstn = 1'b1;
    d = cyc;
    expect_strobe(1'b0, 16'h5A5A, d + LAT);
    step(12);
    dif.btn_load = 1'b0;
    step(12);

    // Long hold with switch change: repeats only with the auto-repeat build
    dif.sw = 16'h0001;
    step(3);
    dif.btn_load = 1'b1;
    d = cyc;
    expect_strobe(1'b0, 16'h0001, d + LAT);
`ifdef AUTO_REPEAT_EN
    expect_strobe(1'b0, 16'h0002, d + 20);
    expect_strobe(1'b0, 16'h0002, d + 33);
`endif
    step(12);
    dif.sw = 16'h0002;
    step(26);
    dif.btn_load = 1'b0;
    step(12);
    check("hold_idle", 32'(dif.busy), 32'd0);
`ifdef AUTO_REPEAT_EN
    check("hold_datos", 32'(dif.Datos), 32'h00000002);
`else
    check("hold_datos", 32'(dif.Datos), 32'h00000001);
`endif

    step(5);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
